// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch stage between the PC register and decode.
// Accepts fetch addresses, issues them to instruction memory, tags each
// in-order response with its PC and queues {pc, instruction} in a DEPTH-entry
// FIFO. A credit check stalls the PC so the FIFO can never overflow. Flush
// kills everything held and still in flight.
//
// Ports:
//   clk, Rst                  clock, synchronous active-high reset
//   pc_in, pc_valid, pc_ready fetch address handshake (pc_ready=0 stalls PC)
//   imem_req, imem_addr       memory read strobe / address
//   imem_rdata, imem_rvalid   in-order memory read response
//   Flush                     redirect; discards held and in-flight fetches
//   inst_out, inst_pc         FIFO head instruction and its PC
//   inst_valid, inst_ready    head handshake towards decode
module fetch_buffer #(
  parameter int unsigned DEPTH     = 2,
  parameter int unsigned MAX_OUTST = 2
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_rvalid,
  input  logic        Flush,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned TW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = $clog2(MAX_OUTST) + 1;

  // Instruction FIFO
  logic [31:0]   data_mem [DEPTH];
  logic [31:0]   pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Tag queue: PCs of requests still owed a response, in issue order
  logic [31:0]   tag_mem [MAX_OUTST];
  logic [TW-1:0] tag_wr;
  logic [TW-1:0] tag_rd;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] drop;

  logic          issue;
  logic          retire;
  logic          push;
  logic          pop;
  logic [CW:0]   credit_used;

  // Every in-flight request holds a FIFO slot, so a response can always be
  // pushed. Responses that will be dropped still hold their slot until they
  // arrive; this is conservative but keeps the check to a single adder.
  always_comb begin
    credit_used = {1'b0, count} + (CW+1)'(outstanding);
    pc_ready    = !Rst && !Flush
                  && (outstanding < OW'(MAX_OUTST))
                  && (credit_used < (CW+1)'(DEPTH));
    issue       = pc_valid && pc_ready;
    imem_req    = issue;
    imem_addr   = pc_in;
    retire      = imem_rvalid;
    push        = retire && (drop == '0) && !Flush;
    inst_valid  = (count != '0);
    pop         = inst_valid && inst_ready && !Flush;
    inst_out    = inst_valid ? data_mem[rd_ptr] : '0;
    inst_pc     = inst_valid ? pc_mem[rd_ptr]   : '0;
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      if (issue) begin
        tag_mem[tag_wr] <= pc_in;
        tag_wr          <= (tag_wr == TW'(MAX_OUTST - 1)) ? '0 : tag_wr + 1'b1;
      end
      // Dropped responses still consume their tag so the queue stays aligned
      if (retire) begin
        tag_rd <= (tag_rd == TW'(MAX_OUTST - 1)) ? '0 : tag_rd + 1'b1;
      end
      outstanding <= outstanding + OW'(issue) - OW'(retire);

      // Everything still owed after this edge is wrong-path; a response
      // retiring in the flush cycle itself is already accounted for.
      if (Flush) begin
        drop <= outstanding - OW'(retire);
      end else if (retire && (drop != '0)) begin
        drop <= drop - 1'b1;
      end

      if (Flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) begin
          data_mem[wr_ptr] <= imem_rdata;
          pc_mem[wr_ptr]   <= tag_mem[tag_rd];
          wr_ptr           <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  rvalid_needs_request: assert property (
    @(posedge clk) disable iff (Rst) imem_rvalid |-> (outstanding != '0)
  );

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: self-checking bench for fetch_buffer (DEPTH=4, MAX_OUTST=2).
// The reference model keeps the FIFO and the in-flight fetches as queues; a
// flush marks in-flight fetches as killed rather than counting drops. An
// in-order memory model answers each request after a configurable latency.
module tb_fetch_buffer;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        Rst, pc_valid, pc_ready, imem_req, imem_rvalid, Flush;
  logic        inst_valid, inst_ready;
  logic [31:0] pc_in, imem_addr, imem_rdata, inst_out, inst_pc;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTST(MAX_OUTST)) dut (
    .clk(clk), .Rst(Rst), .pc_in(pc_in), .pc_valid(pc_valid),
    .pc_ready(pc_ready), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid), .Flush(Flush),
    .inst_out(inst_out), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
  typedef struct { logic [31:0] pc; bit killed; } fetch_t;
  typedef struct { logic [31:0] addr; int due; } memreq_t;
  typedef struct {
    logic rst; logic pcv; logic [31:0] pc;
    logic exp_ready; logic exp_valid; logic [31:0] exp_pc; bit chk_pc;
  } vec_t;

  inst_t   fifo_q[$];
  fetch_t  inflight[$];
  memreq_t mem_q[$];

  int  cyc = 0;
  int  lat = 1;
  bit  lat_rand = 1'b0;
  bit  chk_en = 1'b0;
  int  checks = 0;
  int  errors = 0;

  logic        obs_ready, obs_req, obs_valid, obs_rvalid;
  logic [31:0] obs_pc, obs_out, obs_addr;

  logic [31:0] next_pc;
  int  acc, nd, nrv, dout, maxo, cap_hits, cur;
  bit  got, accepted;
  vec_t tbl[7];

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the
  // model and the memory at the rising edge.
  task automatic step(input logic rst, input logic fl, input logic pcv,
                      input logic [31:0] pc, input logic irdy);
    logic   exp_ready;
    fetch_t f;
    Rst = rst; Flush = fl; pc_valid = pcv; pc_in = pc; inst_ready = irdy;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_data(mem_q[0].addr);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #4;
    obs_ready = pc_ready; obs_req = imem_req; obs_valid = inst_valid;
    obs_rvalid = imem_rvalid; obs_pc = inst_pc; obs_out = inst_out;
    obs_addr = imem_addr;
    exp_ready = !rst && !fl && (inflight.size() < MAX_OUTST)
                && (fifo_q.size() + inflight.size() < DEPTH);
    if (chk_en) begin
      chk("pc_ready", pc_ready, exp_ready);
      chk("imem_req", imem_req, pcv && exp_ready);
      if (pcv && exp_ready) chk("imem_addr", imem_addr, pc);
      chk("inst_valid", inst_valid, fifo_q.size() > 0);
      if (fifo_q.size() > 0) begin
        chk("inst_pc", inst_pc, fifo_q[0].pc);
        chk("inst_out", inst_out, fifo_q[0].data);
      end
    end
    @(posedge clk);
    if (rst) begin
      fifo_q.delete();
      inflight.delete();
      mem_q.delete();
    end else begin
      if (!fl && fifo_q.size() > 0 && irdy) void'(fifo_q.pop_front());
      if (imem_rvalid && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (!f.killed && !fl) fifo_q.push_back('{pc: f.pc, data: imem_rdata});
      end
      if (fl) begin
        fifo_q.delete();
        foreach (inflight[i]) inflight[i].killed = 1'b1;
      end
      if (pcv && exp_ready) inflight.push_back('{pc: pc, killed: 1'b0});
      if (imem_rvalid) void'(mem_q.pop_front());
      if (obs_req)
        mem_q.push_back('{addr: obs_addr,
                          due: cyc + (lat_rand ? int'($urandom_range(1, 4)) : lat)});
    end
    cyc++;
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((fifo_q.size() > 0 || inflight.size() > 0 || mem_q.size() > 0) && n < 20) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      n++;
    end
    chk("drain_done", (fifo_q.size() + inflight.size() + mem_q.size()) == 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1 vectors: 1-cycle memory, decode always ready
    tbl[0] = '{1'b1, 1'b0, 32'h0,    1'b0, 1'b0, 32'h0,    1'b1};
    tbl[1] = '{1'b0, 1'b1, 32'h3000, 1'b1, 1'b0, 32'h0,    1'b1};
    tbl[2] = '{1'b0, 1'b1, 32'h3004, 1'b1, 1'b0, 32'h0,    1'b0};
    tbl[3] = '{1'b0, 1'b1, 32'h3008, 1'b1, 1'b1, 32'h3000, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3004, 1'b1};
    tbl[5] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 32'h3008, 1'b1};
    tbl[6] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b0, 32'h0,    1'b0};

    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    chk_en = 1'b1;

    // Test 1
    lat = 1;
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].rst, 1'b0, tbl[i].pcv, tbl[i].pc, 1'b1);
      chk("t1_pc_ready", obs_ready, tbl[i].exp_ready);
      chk("t1_inst_valid", obs_valid, tbl[i].exp_valid);
      if (tbl[i].chk_pc) begin
        chk("t1_inst_pc", obs_pc, tbl[i].exp_pc);
        chk("t1_inst_out", obs_out, tbl[i].exp_valid ? mem_data(tbl[i].exp_pc) : 32'h0);
      end
    end

    // Test 2: decode stalled, FIFO fills, head holds
    next_pc = 32'h3200; acc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b1, next_pc, 1'b0);
      if (obs_ready) begin acc++; next_pc += 4; end
      if (obs_valid) begin
        chk("t2_head_pc_stable", obs_pc, 32'h3200);
        chk("t2_head_out_stable", obs_out, mem_data(32'h3200));
      end
    end
    chk("t2_accepted", acc, DEPTH);
    chk("t2_ready_low_when_full", obs_ready, 1'b0);
    nd = 0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        chk("t2_drain_pc", obs_pc, 32'h3200 + 4 * nd);
        chk("t2_drain_out", obs_out, mem_data(32'h3200 + 4 * nd));
        nd++;
      end
    end
    chk("t2_delivered", nd, DEPTH);
    drain();

    // Test 3: 3-cycle memory, outstanding cap
    lat = 3; next_pc = 32'h3300; acc = 0; nd = 0; dout = 0; maxo = 0; cap_hits = 0;
    for (int i = 0; i < 30; i++) begin
      cur = dout;
      step(1'b0, 1'b0, i < 16, next_pc, 1'b1);
      if (cur == MAX_OUTST) begin
        cap_hits++;
        chk("t3_ready_at_cap", obs_ready, 1'b0);
      end
      if (i < 16 && obs_ready) begin acc++; next_pc += 4; end
      if (obs_valid) begin
        chk("t3_order", obs_pc, 32'h3300 + 4 * nd);
        nd++;
      end
      dout = dout + int'(obs_req) - int'(obs_rvalid);
      if (dout > maxo) maxo = dout;
    end
    chk("t3_max_inflight", maxo, MAX_OUTST);
    chk("t3_cap_hit", cap_hits > 0, 1'b1);
    chk("t3_all_delivered", nd, acc);
    drain();

    // Test 4: flush with 1 FIFO entry and 2 fetches in flight, then a second flush
    step(1'b0, 1'b0, 1'b1, 32'h3000, 1'b0);
    chk("t4_first_accept", obs_ready, 1'b1);
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      if (obs_valid) got = 1'b1;
    end
    chk("t4_fill_timeout", got, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h3004, 1'b0);
    chk("t4_accept_a", obs_ready, 1'b1);
    step(1'b0, 1'b0, 1'b1, 32'h3008, 1'b0);
    chk("t4_accept_b", obs_ready, 1'b1);
    step(1'b0, 1'b1, 1'b1, 32'h300C, 1'b1);
    chk("t4_no_req_in_flush", obs_req, 1'b0);
    chk("t4_valid_before_flush", obs_valid, 1'b1);
    nrv = 0;
    step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("t4_valid_after_flush", obs_valid, 1'b0);
    nrv += int'(obs_rvalid);
    got = 1'b0; accepted = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step(1'b0, 1'b0, !accepted, 32'h3100, 1'b1);
      if (obs_valid) begin
        got = 1'b1;
        chk("t4_post_flush_pc", obs_pc, 32'h3100);
        chk("t4_post_flush_out", obs_out, mem_data(32'h3100));
      end else begin
        nrv += int'(obs_rvalid);
      end
      if (!accepted && obs_ready) accepted = 1'b1;
    end
    chk("t4_post_flush_timeout", got, 1'b1);
    chk("t4_rvalids_before_delivery", nrv, 3);
    drain();

    // Test 5: steady streaming, request and response every cycle
    lat = 1; next_pc = 32'h3500;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b0, 1'b1, next_pc, 1'b1);
      if (obs_ready) next_pc += 4;
      if (i >= 2) begin
        chk("t5_ready_steady", obs_ready, 1'b1);
        chk("t5_req_and_rvalid", obs_rvalid && obs_req, 1'b1);
        chk("t5_valid_steady", obs_valid, 1'b1);
      end
    end

    // Test 6: reset mid-stream
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0, 1'b1, next_pc, 1'b1);
      if (obs_ready) next_pc += 4;
    end
    step(1'b1, 1'b0, 1'b1, next_pc, 1'b1);
    chk("t6_ready_in_rst", obs_ready, 1'b0);
    step(1'b0, 1'b0, 1'b1, 32'h4000, 1'b0);
    chk("t6_valid_after_rst", obs_valid, 1'b0);
    chk("t6_ready_after_rst", obs_ready, 1'b1);
    chk("t6_pc_zero", obs_pc, 32'h0);
    chk("t6_out_zero", obs_out, 32'h0);
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      if (obs_valid) begin
        got = 1'b1;
        chk("t6_resume_pc", obs_pc, 32'h4000);
        chk("t6_resume_out", obs_out, mem_data(32'h4000));
      end
    end
    chk("t6_resume_timeout", got, 1'b1);
    drain();

    // Randomized traffic against the queue model
    lat_rand = 1'b1; next_pc = 32'h8000;
    for (int i = 0; i < 600; i++) begin
      logic r, f, v, d;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 11) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 3) != 0);
      step(r, f, v, next_pc, d);
      if (v && obs_ready) next_pc += 4;
      if (f) next_pc = 32'h8000 + ($urandom_range(0, 255) << 2);
    end
    lat_rand = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
